// File: rtl/regfile_param.sv
// Parametrised register file: NUM_RD combinational read ports, one write port,
// hardwired-zero x0, pending-write scoreboard and a sequenced clear FSM.
// Optional write-through forwarding is enabled by defining RF_BYPASS_EN.
module regfile_param #(
  parameter  int XLEN   = 32,
  parameter  int DEPTH  = 32,
  parameter  int NUM_RD = 2,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_RD*AW-1:0]   rd_addr,
  output logic [NUM_RD*XLEN-1:0] rd_data,
  output logic [NUM_RD-1:0]      rd_pending,
  input  logic                   wr_en,
  input  logic [AW-1:0]          wr_addr,
  input  logic [XLEN-1:0]        wr_data,
  input  logic                   issue_en,
  input  logic [AW-1:0]          issue_addr,
  input  logic                   clr_req,
  output logic                   ready
);

  typedef enum logic {
    ST_CLEAR,
    ST_RUN
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [AW-1:0]     clr_cnt;
  logic [XLEN-1:0]   regs [DEPTH];
  logic [DEPTH-1:0]  pending;
  logic [DEPTH-1:0]  pending_nxt;
  logic              wr_fire;
  logic              issue_fire;

  assign ready      = (state == ST_RUN);
  assign wr_fire    = ready && wr_en && (wr_addr != '0);
  assign issue_fire = ready && issue_en && (issue_addr != '0);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_CLEAR;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_CLEAR: if (clr_cnt == AW'(DEPTH - 1)) state_nxt = ST_RUN;
      ST_RUN:   if (clr_req)                   state_nxt = ST_CLEAR;
      default:                                 state_nxt = ST_CLEAR;
    endcase
  end

  // x0 is never stored, so the sweep starts at 1 and ends at DEPTH-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 clr_cnt <= AW'(1);
    else if (state == ST_CLEAR) clr_cnt <= clr_cnt + 1'b1;
    else if (clr_req)           clr_cnt <= AW'(1);
  end

  // NOTE: the array has no reset branch so it can map onto RAM macros; the
  // CLEAR sweep zeroes it through the single write port instead.
  always_ff @(posedge clk) begin
    if (!ready)       regs[clr_cnt] <= '0;
    else if (wr_fire) regs[wr_addr] <= wr_data;
  end

  // NOTE: every combinational output gets a default first so no latch is
  // inferred; the issue assignment comes last so it wins over a same-edge write.
  always_comb begin
    pending_nxt = pending;
    if (ready) begin
      if (clr_req) begin
        pending_nxt = '0;
      end else begin
        if (wr_en)      pending_nxt[wr_addr]    = 1'b0;
        if (issue_fire) pending_nxt[issue_addr] = 1'b1;
      end
    end
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending <= '0;
    else        pending <= pending_nxt;
  end

  always_comb begin
    logic [AW-1:0] ra;
    rd_data    = '0;
    rd_pending = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      ra = rd_addr[k*AW +: AW];
      if (ready && (ra != '0)) begin
        rd_data[k*XLEN +: XLEN] = regs[ra];
        rd_pending[k]           = pending[ra];
`ifdef RF_BYPASS_EN
        if (wr_fire && (wr_addr == ra)) begin
          rd_data[k*XLEN +: XLEN] = wr_data;
          rd_pending[k]           = issue_fire && (issue_addr == ra);
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_regfile_param.sv
// Self-checking bench for regfile_param: directed scenarios plus randomized
// traffic against a behavioural model of registers, scoreboard and clear timing.
module tb_regfile_param;

  localparam int XLEN   = 32;
  localparam int DEPTH  = 32;
  localparam int NUM_RD = 2;
  localparam int AW     = $clog2(DEPTH);

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [NUM_RD*AW-1:0]   rd_addr;
  logic [NUM_RD*XLEN-1:0] rd_data;
  logic [NUM_RD-1:0]      rd_pending;
  logic                   wr_en;
  logic [AW-1:0]          wr_addr;
  logic [XLEN-1:0]        wr_data;
  logic                   issue_en;
  logic [AW-1:0]          issue_addr;
  logic                   clr_req;
  logic                   ready;

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model: architectural register values, pending flags and the
  // number of clear cycles still owed before the file becomes usable.
  logic [XLEN-1:0] m_regs [DEPTH];
  bit              m_pend [DEPTH];
  bit              m_ready;
  int              m_left;

  regfile_param #(.XLEN(XLEN), .DEPTH(DEPTH), .NUM_RD(NUM_RD)) dut (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_pending(rd_pending), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .issue_en(issue_en), .issue_addr(issue_addr), .clr_req(clr_req), .ready(ready)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_ready = 1'b0;
    m_left  = DEPTH - 1;
    for (int i = 0; i < DEPTH; i++) begin
      m_regs[i] = '0;
      m_pend[i] = 1'b0;
    end
  endtask

  // Applies the rules for the coming edge using the inputs now driven, then
  // advances to 1 ns after that edge.
  task automatic tick();
    if (!rst_n) begin
      model_reset();
    end else if (!m_ready) begin
      m_left--;
      if (m_left == 0) m_ready = 1'b1;
    end else if (clr_req) begin
      model_reset();
    end else begin
      if (wr_en && wr_addr != 0) m_regs[wr_addr] = wr_data;
      if (wr_en) m_pend[wr_addr] = 1'b0;
      if (issue_en && issue_addr != 0) m_pend[issue_addr] = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [XLEN-1:0] exp_data(int a);
    if (!m_ready || a == 0) return '0;
`ifdef RF_BYPASS_EN
    if (wr_en && int'(wr_addr) == a) return wr_data;
`endif
    return m_regs[a];
  endfunction

  function automatic logic exp_pend(int a);
    if (!m_ready || a == 0) return 1'b0;
`ifdef RF_BYPASS_EN
    if (wr_en && int'(wr_addr) == a) return issue_en && int'(issue_addr) == a;
`endif
    return m_pend[a];
  endfunction

  function automatic int port_addr(int k);
    return int'(rd_addr[k*AW +: AW]);
  endfunction

  task automatic idle_inputs();
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    issue_en = 1'b0; issue_addr = '0; clr_req = 1'b0;
  endtask

  task automatic set_rd(int k, int a);
    rd_addr[k*AW +: AW] = AW'(a);
  endtask

  task automatic test_reset();
    int lows;
    rst_n = 1'b0; rd_addr = '0; idle_inputs();
    model_reset();
    tick(); tick();
    n_cmp++;
    if (ready !== 1'b0) begin n_err++; $display("FAIL reset_ready got %b want 0", ready); end
    rst_n = 1'b1;
    #1;
    lows = 0;
    while (ready === 1'b0 && lows < 100) begin
      lows++;
      tick();
    end
    n_cmp++;
    if (lows != DEPTH - 1 || ready !== 1'b1) begin
      n_err++; $display("FAIL reset_clear_len got %0d cycles (ready=%b) want %0d", lows, ready, DEPTH - 1);
    end
    for (int i = 0; i < DEPTH; i++) begin
      set_rd(0, i); set_rd(1, DEPTH - 1 - i);
      #1;
      for (int k = 0; k < NUM_RD; k++) begin
        n_cmp++;
        if (rd_data[k*XLEN +: XLEN] !== 32'h0) begin
          n_err++; $display("FAIL reset_read x%0d port%0d got %h want 00000000", port_addr(k), k, rd_data[k*XLEN +: XLEN]);
        end
      end
    end
  endtask

  task automatic test_write_read();
    wr_en = 1'b1; wr_addr = 5; wr_data = 32'hDEADBEEF;
    set_rd(0, 5); set_rd(1, 5);
    #1;
    for (int k = 0; k < NUM_RD; k++) begin
      n_cmp++;
      if (rd_data[k*XLEN +: XLEN] !== exp_data(5)) begin
        n_err++; $display("FAIL same_cycle_read port%0d got %h want %h", k, rd_data[k*XLEN +: XLEN], exp_data(5));
      end
    end
    tick();
    idle_inputs();
    #1;
    for (int k = 0; k < NUM_RD; k++) begin
      n_cmp++;
      if (rd_data[k*XLEN +: XLEN] !== 32'hDEADBEEF) begin
        n_err++; $display("FAIL next_cycle_read port%0d got %h want deadbeef", k, rd_data[k*XLEN +: XLEN]);
      end
    end
  endtask

  task automatic test_zero_reg();
    wr_en = 1'b1; wr_addr = 0; wr_data = 32'h12345678;
    issue_en = 1'b1; issue_addr = 0;
    set_rd(0, 0); set_rd(1, 0);
    tick();
    idle_inputs();
    #1;
    for (int k = 0; k < NUM_RD; k++) begin
      n_cmp++;
      if (rd_data[k*XLEN +: XLEN] !== 32'h0 || rd_pending[k] !== 1'b0) begin
        n_err++; $display("FAIL x0_read port%0d got %h/%b want 00000000/0", k, rd_data[k*XLEN +: XLEN], rd_pending[k]);
      end
    end
  endtask

  task automatic test_scoreboard();
    set_rd(0, 7); set_rd(1, 6);
    issue_en = 1'b1; issue_addr = 7;
    tick();
    idle_inputs();
    for (int c = 0; c < 3; c++) begin
      #1;
      n_cmp++;
      if (rd_pending[0] !== 1'b1) begin n_err++; $display("FAIL x7_pending cycle%0d got %b want 1", c, rd_pending[0]); end
      if (c < 2) tick();
    end
    wr_en = 1'b1; wr_addr = 7; wr_data = 32'h7;
    #1;
    n_cmp++;
    if (rd_pending[0] !== exp_pend(7)) begin n_err++; $display("FAIL x7_pending_wr_cycle got %b want %b", rd_pending[0], exp_pend(7)); end
    tick();
    idle_inputs();
    #1;
    n_cmp++;
    if (rd_pending[0] !== 1'b0 || rd_data[XLEN-1:0] !== 32'h7) begin
      n_err++; $display("FAIL x7_after_write got %h/%b want 00000007/0", rd_data[XLEN-1:0], rd_pending[0]);
    end
    issue_en = 1'b1; issue_addr = 7; wr_en = 1'b1; wr_addr = 7; wr_data = 32'h70;
    tick();
    idle_inputs();
    #1;
    n_cmp++;
    if (rd_pending[0] !== 1'b1) begin n_err++; $display("FAIL x7_issue_and_write got %b want 1", rd_pending[0]); end
    wr_en = 1'b1; wr_addr = 7; wr_data = 32'h77;
    tick();
    idle_inputs();
  endtask

  task automatic test_clr_req();
    int lows;
    wr_en = 1'b1; wr_addr = 3; wr_data = 32'hFFFF;
    issue_en = 1'b1; issue_addr = 4;
    set_rd(0, 3); set_rd(1, 4);
    tick();
    idle_inputs();
    #1;
    n_cmp++;
    if (rd_data[XLEN-1:0] !== 32'hFFFF || rd_pending[1] !== 1'b1) begin
      n_err++; $display("FAIL pre_clear got x3=%h p4=%b want 0000ffff/1", rd_data[XLEN-1:0], rd_pending[1]);
    end
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    #1;
    n_cmp++;
    if (ready !== 1'b0 || rd_pending !== '0 || rd_data !== '0) begin
      n_err++; $display("FAIL clr_drop got ready=%b pend=%b data=%h want 0/0/0", ready, rd_pending, rd_data);
    end
    lows = 0;
    while (ready === 1'b0 && lows < 100) begin
      lows++;
      tick();
    end
    n_cmp++;
    if (lows != DEPTH - 1) begin n_err++; $display("FAIL clr_len got %0d want %0d", lows, DEPTH - 1); end
    n_cmp++;
    if (rd_data[XLEN-1:0] !== 32'h0 || rd_pending[1] !== 1'b0) begin
      n_err++; $display("FAIL post_clear got x3=%h p4=%b want 00000000/0", rd_data[XLEN-1:0], rd_pending[1]);
    end
  endtask

  task automatic test_reset_mid_clear();
    int lows;
    for (int i = 1; i < DEPTH; i += 3) begin
      wr_en = 1'b1; wr_addr = AW'(i); wr_data = $urandom;
      tick();
    end
    idle_inputs();
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int c = 0; c < 15; c++) begin
      wr_en = 1'b1; wr_addr = AW'($urandom_range(1, DEPTH - 1)); wr_data = $urandom;
      tick();
    end
    rst_n = 1'b0;
    model_reset();
    #1;
    n_cmp++;
    if (ready !== 1'b0) begin n_err++; $display("FAIL mid_reset_ready got %b want 0", ready); end
    tick();
    rst_n = 1'b1;
    lows = 0;
    while (ready === 1'b0 && lows < 100) begin
      wr_en = 1'b1; wr_addr = AW'($urandom_range(1, DEPTH - 1)); wr_data = $urandom;
      lows++;
      tick();
    end
    idle_inputs();
    n_cmp++;
    if (lows != DEPTH - 1) begin n_err++; $display("FAIL mid_reset_clear_len got %0d want %0d", lows, DEPTH - 1); end
    for (int i = 0; i < DEPTH; i += 2) begin
      set_rd(0, i); set_rd(1, i + 1);
      #1;
      for (int k = 0; k < NUM_RD; k++) begin
        n_cmp++;
        if (rd_data[k*XLEN +: XLEN] !== 32'h0) begin
          n_err++; $display("FAIL mid_reset_read x%0d got %h want 00000000", port_addr(k), rd_data[k*XLEN +: XLEN]);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      wr_en      = ($urandom_range(0, 2) != 0);
      wr_addr    = AW'($urandom);
      wr_data    = $urandom;
      issue_en   = ($urandom_range(0, 1) != 0);
      issue_addr = ($urandom_range(0, 3) == 0) ? wr_addr : AW'($urandom);
      clr_req    = ($urandom_range(0, 79) == 0);
      for (int k = 0; k < NUM_RD; k++) begin
        if ($urandom_range(0, 3) == 0) set_rd(k, int'(wr_addr));
        else                           set_rd(k, int'($urandom_range(0, DEPTH - 1)));
      end
      #1;
      n_cmp++;
      if (ready !== m_ready) begin n_err++; $display("FAIL rand_ready cyc%0d got %b want %b", c, ready, m_ready); end
      for (int k = 0; k < NUM_RD; k++) begin
        n_cmp++;
        if (rd_data[k*XLEN +: XLEN] !== exp_data(port_addr(k)) || rd_pending[k] !== exp_pend(port_addr(k))) begin
          n_err++;
          $display("FAIL rand_read cyc%0d port%0d x%0d got %h/%b want %h/%b", c, k, port_addr(k),
                   rd_data[k*XLEN +: XLEN], rd_pending[k], exp_data(port_addr(k)), exp_pend(port_addr(k)));
        end
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_zero_reg();
    test_scoreboard();
    test_clr_req();
    test_reset_mid_clear();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
